// File: rtl/vga_pkg.sv
// Shared raster phase encoding and default 640x480@60 timing.
// Constants only; no logic, no latency, no flow control.
package vga_pkg;

    typedef enum logic [1:0] {
        PH_ACTIVE,
        PH_FRONT,
        PH_SYNC,
        PH_BACK
    } phase_t;

    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;
    localparam logic VGA_SYNC_POL = 1'b0;
    localparam int VGA_COORD_W  = 10;

endpackage

// File: rtl/vga_axis_fsm.sv
// One raster axis: position counter plus ACTIVE/FRONT/SYNC/BACK phase tracker.
// Registered outputs update on the edge where en=1; en=0 freezes all state.
module vga_axis_fsm
    import vga_pkg::*;
#(
    parameter int ACTIVE = 640,
    parameter int FP     = 16,
    parameter int SYNC   = 96,
    parameter int BP     = 48,
    parameter int CW     = 10
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    output logic [CW-1:0] count,
    output phase_t        phase,
    output logic          wrap,
    output logic          sync_active
);

    localparam int TOTAL = ACTIVE + FP + SYNC + BP;
    localparam logic [CW-1:0] TOT_M1 = CW'(TOTAL - 1);
    localparam logic [CW-1:0] ACT_M1 = CW'(ACTIVE - 1);
    localparam logic [CW-1:0] FP_M1  = CW'(FP - 1);
    localparam logic [CW-1:0] SY_M1  = CW'(SYNC - 1);
    localparam logic [CW-1:0] BP_M1  = CW'(BP - 1);

    generate
        if (ACTIVE < 1 || FP < 1 || SYNC < 1 || BP < 1) begin : g_bad_len
            $error("vga_axis_fsm: every phase length must be at least 1");
        end
        if (TOTAL > 2**CW) begin : g_bad_width
            $error("vga_axis_fsm: count width too small for axis total");
        end
    endgenerate

    logic [CW-1:0] pcnt;

    assign wrap = en & (count == TOT_M1);

    // pcnt counts down the pixels/lines left in the current phase
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count       <= '0;
            phase       <= PH_ACTIVE;
            pcnt        <= ACT_M1;
            sync_active <= 1'b0;
        end else if (en) begin
            count <= (count == TOT_M1) ? '0 : count + CW'(1);
            if (pcnt != '0) begin
                pcnt <= pcnt - CW'(1);
            end else begin
                case (phase)
                    PH_ACTIVE: begin
                        phase <= PH_FRONT;
                        pcnt  <= FP_M1;
                    end
                    PH_FRONT: begin
                        phase       <= PH_SYNC;
                        pcnt        <= SY_M1;
                        sync_active <= 1'b1;
                    end
                    PH_SYNC: begin
                        phase       <= PH_BACK;
                        pcnt        <= BP_M1;
                        sync_active <= 1'b0;
                    end
                    default: begin
                        phase <= PH_ACTIVE;
                        pcnt  <= ACT_M1;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing from a pixel-rate enable: coordinates, syncs, visible window, line/frame strobes.
// Outputs change on the edge of a pix_en step (1 clk); pix_en=0 holds every output.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int   H_ACTIVE = VGA_H_ACTIVE,
    parameter int   H_FP     = VGA_H_FP,
    parameter int   H_SYNC   = VGA_H_SYNC,
    parameter int   H_BP     = VGA_H_BP,
    parameter int   V_ACTIVE = VGA_V_ACTIVE,
    parameter int   V_FP     = VGA_V_FP,
    parameter int   V_SYNC   = VGA_V_SYNC,
    parameter int   V_BP     = VGA_V_BP,
    parameter logic SYNC_POL = VGA_SYNC_POL,
    parameter int   XW       = VGA_COORD_W,
    parameter int   YW       = VGA_COORD_W
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          pix_en,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic          video_on,
    output logic          hsync,
    output logic          vsync,
    output logic          line_start,
    output logic          frame_start
);

    phase_t h_phase;
    phase_t v_phase;
    logic   h_wrap;
    logic   v_wrap;
    logic   h_sync_act;
    logic   v_sync_act;

    vga_axis_fsm #(
        .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .CW(XW)
    ) u_h_axis (
        .clk        (clk),
        .reset      (reset),
        .en         (pix_en),
        .count      (x),
        .phase      (h_phase),
        .wrap       (h_wrap),
        .sync_active(h_sync_act)
    );

    // vertical axis steps once per completed line
    vga_axis_fsm #(
        .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .CW(YW)
    ) u_v_axis (
        .clk        (clk),
        .reset      (reset),
        .en         (h_wrap),
        .count      (y),
        .phase      (v_phase),
        .wrap       (v_wrap),
        .sync_active(v_sync_act)
    );

    assign hsync    = h_sync_act ? SYNC_POL : ~SYNC_POL;
    assign vsync    = v_sync_act ? SYNC_POL : ~SYNC_POL;
    assign video_on = (h_phase == PH_ACTIVE) && (v_phase == PH_ACTIVE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            line_start  <= h_wrap;
            frame_start <= v_wrap;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: small-geometry instance over whole frames plus a 640x480 instance over a few lines.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int ha; int hf; int hs; int hb;
        int va; int vf; int vs; int vb;
        bit pol;
    } tim_t;

    typedef struct { int x; int y; bit ls; bit fs; } mst_t;
    typedef struct { int x; int y; bit vo; bit hs; bit vs; bit ls; bit fs; } exp_t;

    int cmps = 0;
    int errs = 0;

    logic       rst_s = 1'b0, en_s = 1'b0;
    logic [3:0] x_s, y_s;
    logic       vo_s, hs_s, vs_s, ls_s, fs_s;

    logic       rst_d = 1'b0, en_d = 1'b0;
    logic [9:0] x_d, y_d;
    logic       vo_d, hs_d, vs_d, ls_d, fs_d;

    vga_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .SYNC_POL(1'b1), .XW(4), .YW(4)
    ) dut_s (
        .clk(clk), .reset(rst_s), .pix_en(en_s), .x(x_s), .y(y_s),
        .video_on(vo_s), .hsync(hs_s), .vsync(vs_s),
        .line_start(ls_s), .frame_start(fs_s)
    );

    vga_timing_gen dut_d (
        .clk(clk), .reset(rst_d), .pix_en(en_d), .x(x_d), .y(y_d),
        .video_on(vo_d), .hsync(hs_d), .vsync(vs_d),
        .line_start(ls_d), .frame_start(fs_d)
    );

    tim_t ts = '{4, 1, 1, 1, 3, 1, 1, 1, 1'b1};
    tim_t td = '{640, 16, 96, 48, 480, 10, 2, 33, 1'b0};
    mst_t ms = '{0, 0, 1'b0, 1'b0};
    mst_t md = '{0, 0, 1'b0, 1'b0};
    exp_t q_s[$];
    exp_t q_d[$];

    function automatic mst_t mnext(mst_t m, tim_t t, bit rn, bit en);
        int ht = t.ha + t.hf + t.hs + t.hb;
        int vt = t.va + t.vf + t.vs + t.vb;
        mst_t r = m;
        if (!rn) begin
            r = '{0, 0, 1'b0, 1'b0};
        end else begin
            r.ls = en && (m.x == ht - 1);
            r.fs = r.ls && (m.y == vt - 1);
            if (en) r.x = (m.x == ht - 1) ? 0 : m.x + 1;
            if (r.ls) r.y = (m.y == vt - 1) ? 0 : m.y + 1;
        end
        return r;
    endfunction

    function automatic exp_t mexp(mst_t m, tim_t t);
        exp_t e;
        e.x  = m.x;
        e.y  = m.y;
        e.vo = (m.x < t.ha) && (m.y < t.va);
        e.hs = (m.x >= t.ha + t.hf && m.x < t.ha + t.hf + t.hs) ? t.pol : !t.pol;
        e.vs = (m.y >= t.va + t.vf && m.y < t.va + t.vf + t.vs) ? t.pol : !t.pol;
        e.ls = m.ls;
        e.fs = m.fs;
        return e;
    endfunction

    task automatic chk(input string nm, input int act, input int exp_v);
        cmps++;
        if (act != exp_v) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp_v, $time);
        end
    endtask

    task automatic cmp_tuple(input string nm, input exp_t a, input exp_t e);
        cmps++;
        if (a.x != e.x || a.y != e.y || a.vo != e.vo || a.hs != e.hs ||
            a.vs != e.vs || a.ls != e.ls || a.fs != e.fs) begin
            errs++;
            $display("FAIL %s: got x=%0d y=%0d vo=%0d hs=%0d vs=%0d ls=%0d fs=%0d expected x=%0d y=%0d vo=%0d hs=%0d vs=%0d ls=%0d fs=%0d (t=%0t)",
                     nm, a.x, a.y, a.vo, a.hs, a.vs, a.ls, a.fs,
                     e.x, e.y, e.vo, e.hs, e.vs, e.ls, e.fs, $time);
        end
    endtask

    task automatic step_s(input bit r, input bit e);
        @(negedge clk);
        rst_s = r;
        en_s  = e;
        ms = mnext(ms, ts, r, e);
        q_s.push_back(mexp(ms, ts));
    endtask

    task automatic step_d(input bit r, input bit e);
        @(negedge clk);
        rst_d = r;
        en_d  = e;
        md = mnext(md, td, r, e);
        q_d.push_back(mexp(md, td));
    endtask

    // scoreboard monitor: one popped expectation per sampled clk
    initial begin
        exp_t e, a;
        forever begin
            @(posedge clk);
            #1;
            if (q_s.size() > 0) begin
                e = q_s.pop_front();
                a = '{int'(x_s), int'(y_s), vo_s, hs_s, vs_s, ls_s, fs_s};
                cmp_tuple("small_raster", a, e);
            end
            if (q_d.size() > 0) begin
                e = q_d.pop_front();
                a = '{int'(x_d), int'(y_d), vo_d, hs_d, vs_d, ls_d, fs_d};
                cmp_tuple("vga_raster", a, e);
            end
        end
    end

    bit cnt_s = 1'b0, cnt_d = 1'b0;
    int fsc = 0, lsc = 0, voc = 0, fsd = 0, lsd = 0;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (cnt_s) begin
                if (fs_s) fsc++;
                if (ls_s) lsc++;
                if (vo_s) voc++;
            end
            if (cnt_d) begin
                if (fs_d) fsd++;
                if (ls_d) lsd++;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not reach the end in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // small geometry: 7 x 6 raster, active-high syncs
        step_s(0, 0);
        step_s(0, 1);
        step_s(1, 0);
        step_s(1, 1);
        cnt_s = 1'b1;
        repeat (125) step_s(1, 1);
        step_s(1, 0);
        cnt_s = 1'b0;
        chk("frames3_frame_start_count", fsc, 3);
        chk("frames3_line_start_count", lsc, 18);
        chk("frames3_video_on_count", voc, 36);

        fsc = 0; lsc = 0;
        cnt_s = 1'b1;
        for (int i = 0; i < 168; i++) step_s(1, (i % 4) == 0);
        step_s(1, 0);
        cnt_s = 1'b0;
        chk("quarter_rate_frame_start_count", fsc, 1);
        chk("quarter_rate_line_start_count", lsc, 6);

        // 640x480 instance
        step_d(0, 0);
        step_d(0, 1);
        step_d(1, 0);
        repeat (655) step_d(1, 1);
        @(posedge clk); #2;
        chk("x_at_655", int'(x_d), 655);
        chk("hsync_high_at_655", int'(hs_d), 1);
        repeat (1000) step_d(1, 0);
        @(posedge clk); #2;
        chk("x_frozen_655", int'(x_d), 655);
        chk("hsync_frozen_high", int'(hs_d), 1);
        step_d(1, 1);
        @(posedge clk); #2;
        chk("x_at_656", int'(x_d), 656);
        chk("hsync_falls_at_656", int'(hs_d), 0);
        repeat (95) step_d(1, 1);
        @(posedge clk); #2;
        chk("hsync_low_at_751", int'(hs_d), 0);
        step_d(1, 1);
        @(posedge clk); #2;
        chk("hsync_rises_at_752", int'(hs_d), 1);
        repeat (48) step_d(1, 1);
        @(posedge clk); #2;
        chk("x_wrap_to_0", int'(x_d), 0);
        chk("y_after_first_line", int'(y_d), 1);
        chk("line_start_after_wrap", int'(ls_d), 1);
        repeat (700) step_d(1, 1);
        @(posedge clk); #2;
        chk("x_at_700_before_reset", int'(x_d), 700);

        @(negedge clk);
        rst_d = 1'b0;
        md = mnext(md, td, 1'b0, 1'b0);
        #1;
        chk("async_reset_x", int'(x_d), 0);
        chk("async_reset_y", int'(y_d), 0);
        chk("async_reset_hsync", int'(hs_d), 1);
        chk("async_reset_vsync", int'(vs_d), 1);
        chk("async_reset_video_on", int'(vo_d), 1);
        repeat (3) step_d(0, 1);
        step_d(1, 1);
        cnt_d = 1'b1;
        repeat (1699) step_d(1, 1);
        step_d(1, 0);
        cnt_d = 1'b0;
        chk("no_frame_start_after_reset", fsd, 0);
        chk("line_starts_after_reset", lsd, 2);

        repeat (3) @(negedge clk);
        chk("small_queue_drained", q_s.size(), 0);
        chk("vga_queue_drained", q_d.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
        $finish;
    end

endmodule
